// File: rtl/fixed_point_divider.sv
// Sequential unsigned fixed-point divider: quotient = (dividend << frac_p) / divisor,
// restoring shift-subtract, one quotient bit per cycle, valid/ready in and valid/yumi out.
module fixed_point_divider #(
  parameter int width_p = 8,
  parameter int frac_p  = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [width_p-1:0]        dividend_i,
  input  logic [width_p-1:0]        divisor_i,
  output logic                      valid_o,
  input  logic                      yumi_i,
  output logic [width_p-1:-frac_p]  quotient_o,
  output logic [width_p-1:0]        remainder_o,
  output logic                      div_by_zero_o
);

  localparam int n_lp     = width_p + frac_p;
  localparam int cnt_w_lp = $clog2(n_lp + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e               state, state_next;
  logic [cnt_w_lp-1:0]  count;
  logic [width_p-1:0]   rem;
  logic [width_p-1:0]   divisor;
  logic [n_lp-1:0]      ext_shift;
  logic [n_lp-1:0]      quot_shift;

  logic                 accept;
  logic                 last_step;
  logic [width_p:0]     partial;
  logic [width_p:0]     diff;
  logic                 q_bit;
  logic [width_p-1:0]   rem_next;
  logic [n_lp-1:0]      quot_next;

  assign accept    = valid_i && (state == IDLE);
  assign last_step = (count == '0);

  // One restoring step: bring down the next extended-dividend bit and try the subtract.
  // partial < 2*divisor, so whichever value is kept fits back into width_p bits.
  always_comb begin
    partial   = {rem, ext_shift[n_lp-1]};
    diff      = partial - {1'b0, divisor};
    q_bit     = (partial >= {1'b0, divisor});
    rem_next  = q_bit ? diff[width_p-1:0] : partial[width_p-1:0];
    quot_next = (quot_shift << 1) | n_lp'(q_bit);
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: every case item assigns state_next after a default, so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (divisor_i == '0) ? DONE : BUSY;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    if (yumi_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state == IDLE);
    valid_o = (state == DONE);
  end

  // Result registers only change on a load, so they hold through DONE and after yumi.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count         <= '0;
      rem           <= '0;
      divisor       <= '0;
      ext_shift     <= '0;
      quot_shift    <= '0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            divisor    <= divisor_i;
            rem        <= '0;
            ext_shift  <= n_lp'(dividend_i) << frac_p;
            quot_shift <= '0;
            count      <= cnt_w_lp'(n_lp - 1);
            if (divisor_i == '0) begin
              quotient_o    <= '1;
              remainder_o   <= dividend_i;
              div_by_zero_o <= 1'b1;
            end
          end
        end
        BUSY: begin
          rem        <= rem_next;
          ext_shift  <= ext_shift << 1;
          quot_shift <= quot_next;
          count      <= count - 1'b1;
          if (last_step) begin
            quotient_o    <= quot_next;
            remainder_o   <= rem_next;
            div_by_zero_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_divider.sv
// Self-checking bench for fixed_point_divider: directed cases, backpressure, mid-op reset,
// a pairwise sweep and random operands against an arithmetic reference model.
module tb_fixed_point_divider;

  localparam int W = 8;
  localparam int F = 4;
  localparam int N = W + F;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              valid_i;
  logic              ready_o;
  logic [W-1:0]      dividend_i;
  logic [W-1:0]      divisor_i;
  logic              valid_o;
  logic              yumi_i;
  logic [W-1:-F]     quotient_o;
  logic [W-1:0]      remainder_o;
  logic              div_by_zero_o;

  int checks   = 0;
  int failures = 0;

  fixed_point_divider #(.width_p(W), .frac_p(F)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .valid_o      (valid_o),
    .yumi_i       (yumi_i),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o),
    .div_by_zero_o(div_by_zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain integer arithmetic on the scaled dividend.
  task automatic model(input int unsigned a, input int unsigned b,
                       output logic [N-1:0] q, output logic [W-1:0] r);
    if (b == 0) begin
      q = '1;
      r = W'(a);
    end else begin
      q = N'((a * (1 << F)) / b);
      r = W'((a * (1 << F)) % b);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Runs one operation; stall = cycles yumi is held low while valid, yumi_early = yumi high throughout.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [N-1:0] exp_q, input logic [W-1:0] exp_r,
                        input int stall, input bit yumi_early);
    int lat;
    int budget;
    budget = 0;
    while (!ready_o && budget < 50) begin
      tick();
      budget++;
    end
    check("ready_before_op", ready_o, 1'b1);
    valid_i    = 1'b1;
    dividend_i = a;
    divisor_i  = b;
    tick();
    valid_i    = 1'b0;
    dividend_i = W'($urandom);
    divisor_i  = W'($urandom);
    if (yumi_early) yumi_i = 1'b1;
    if (b != 0) check("ready_low_busy", ready_o, 1'b0);
    lat = 0;
    while (!valid_o && lat < 100) begin
      tick();
      lat++;
    end
    // Divide-by-zero results are visible in the cycle right after the accepting edge.
    check("latency_edges", lat, (b == 0) ? 0 : N);
    check("valid_out", valid_o, 1'b1);
    check("ready_in_done", ready_o, 1'b0);
    check("quotient", quotient_o, exp_q);
    check("remainder", remainder_o, exp_r);
    check("div_by_zero", div_by_zero_o, (b == 0));
    if (b != 0)
      check("identity", 32'(quotient_o) * 32'(b) + 32'(remainder_o), 32'(a) << F);
    if (!yumi_early) begin
      for (int i = 0; i < stall; i++) begin
        valid_i    = 1'b1;
        dividend_i = W'($urandom);
        divisor_i  = W'($urandom);
        tick();
        valid_i = 1'b0;
        check("stall_valid", valid_o, 1'b1);
        check("stall_ready", ready_o, 1'b0);
        check("stall_quotient", quotient_o, exp_q);
        check("stall_remainder", remainder_o, exp_r);
      end
      yumi_i = 1'b1;
    end
    tick();
    yumi_i = 1'b0;
    check("valid_after_yumi", valid_o, 1'b0);
    check("ready_after_yumi", ready_o, 1'b1);
    check("held_quotient", quotient_o, exp_q);
  endtask

  int unsigned vals [20] = '{0, 1, 2, 3, 4, 5, 7, 15, 31, 63, 127, 255,
                             8, 16, 32, 64, 128, 100, 200, 254};

  initial begin
    logic [N-1:0] mq;
    logic [W-1:0] mr;
    logic [W-1:0] ra, rb;
    bit seen;

    reset_i    = 1'b1;
    valid_i    = 1'b0;
    yumi_i     = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    #3;
    check("rst_ready", ready_o, 1'b1);
    check("rst_valid", valid_o, 1'b0);
    check("rst_quotient", quotient_o, 0);
    check("rst_remainder", remainder_o, 0);
    check("rst_dbz", div_by_zero_o, 1'b0);
    tick();
    reset_i = 1'b0;
    tick();

    run_op(8'd100, 8'd7,   12'h0E4, 8'd4,  0, 1'b1);
    run_op(8'd255, 8'd1,   12'hFF0, 8'd0,  0, 1'b0);
    run_op(8'd1,   8'd255, 12'h000, 8'd16, 0, 1'b0);
    run_op(8'd0,   8'd5,   12'h000, 8'd0,  0, 1'b0);
    run_op(8'd7,   8'd0,   12'hFFF, 8'd7,  0, 1'b0);
    run_op(8'd200, 8'd3,   12'h42A, 8'd2,  5, 1'b0);

    // Reset during the sixth BUSY cycle must abort with no result.
    valid_i    = 1'b1;
    dividend_i = 8'd100;
    divisor_i  = 8'd7;
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2 reset_i = 1'b1;
    #1;
    check("abort_ready", ready_o, 1'b1);
    check("abort_valid", valid_o, 1'b0);
    check("abort_quotient", quotient_o, 0);
    tick();
    reset_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid_o) seen = 1'b1;
    end
    check("abort_no_result", seen, 1'b0);
    run_op(8'd100, 8'd7, 12'h0E4, 8'd4, 0, 1'b0);

    foreach (vals[i]) begin
      foreach (vals[j]) begin
        model(W'(vals[i]), W'(vals[j]), mq, mr);
        run_op(W'(vals[i]), W'(vals[j]), mq, mr, 0, 1'b0);
      end
    end

    for (int k = 0; k < 40; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (k % 8 == 0) rb = '0;
      model(ra, rb, mq, mr);
      run_op(ra, rb, mq, mr, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fixed_point_divider.md
Name: fixed_point_divider

Overview:
- Sequential unsigned fixed-point divider; the inverse operation of the team's combinational fixed-point multiplier.
- Computes quotient = (dividend << frac_p) / divisor as a fixed-point value with frac_p fractional bits, plus the integer remainder.
- Uses a restoring shift-subtract algorithm, one quotient bit per cycle.
- Sits beside the multiplier in the arithmetic datapath, with valid/ready on input and valid/yumi on output.

Parameters:
- width_p, 8, integer width of dividend, divisor and remainder.
- frac_p, 4, number of fractional quotient bits; number of iterations is width_p+frac_p.

Ports:
- clk_i  input  1  clock, rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  operands valid.
- ready_o  output  1  divider can accept operands.
- dividend_i  input  width_p  unsigned dividend, integer.
- divisor_i  input  width_p  unsigned divisor, integer.
- valid_o  output  1  result valid.
- yumi_i  input  1  consumer takes result; legal only while valid_o=1.
- quotient_o  output  [width_p-1:-frac_p]  unsigned fixed-point quotient.
- remainder_o  output  width_p  remainder, always less than the divisor.
- div_by_zero_o  output  1  result came from divisor_i==0.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - ready_o=1, valid_o=0, quotient_o=0, remainder_o=0, div_by_zero_o=0.
  - Internal counter, partial remainder and shift register are cleared.
  - Reset mid-BUSY or mid-DONE aborts the operation; no result is emitted.
- States: IDLE, BUSY, DONE.
- IDLE:
  - ready_o=1, valid_o=0.
  - Accept when valid_i&ready_o at a rising edge. Operands are latched; the caller may change them afterwards.
  - divisor_i!=0: go to BUSY, counter=width_p+frac_p-1.
  - divisor_i==0: go directly to DONE with quotient_o all ones (0xFFF at defaults), remainder_o=dividend_i, div_by_zero_o=1. valid_o rises on the next cycle (latency 1).
- BUSY:
  - ready_o=0, valid_o=0.
  - Each cycle: partial remainder (width_p+1 bits) = {rem, next MSB of extended dividend {dividend, frac_p zeros}}.
  - If partial remainder >= divisor: subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
  - Counter decrements each cycle. At counter==0 the final bit is written, the result registers load, div_by_zero_o=0, and state goes to DONE.
  - Latency: valid_o asserts exactly width_p+frac_p cycles after the accepting edge (12 at defaults).
- DONE:
  - valid_o=1, ready_o=0.
  - quotient_o, remainder_o and div_by_zero_o are held stable.
  - On yumi_i=1: go to IDLE; valid_o=0 and ready_o=1 on the next cycle.
  - No accept occurs in the same cycle as yumi_i. Minimum operation interval is N+2 cycles.
- Result outputs hold their last value after yumi until the next result loads; consumers qualify them with valid_o.
- valid_i while not ready is ignored; no operands are captured.
- yumi_i while valid_o=0 is illegal; the block ignores it.
- Arithmetic rules:
  - quotient_o = floor(dividend*2^frac_p / divisor).
  - remainder_o = dividend*2^frac_p mod divisor.
  - Quotient never overflows: the maximum is (2^width_p-1)*2^frac_p, which fits width_p+frac_p bits.
- Operands 0 and divisor 1 need no special casing; they take the full N cycles.

Test Plan:
- Reset, then check outputs: ready_o=1, valid_o=0, quotient_o=0, remainder_o=0, div_by_zero_o=0.
- 100/7 with yumi_i held high → valid_o at exactly +12 cycles; quotient_o=0x0E4 (14.25), remainder_o=4, div_by_zero_o=0; ready_o=1 on the cycle after yumi.
- 255/1 → quotient_o=0xFF0 (255.0), remainder_o=0.
- 1/255 → quotient_o=0x000, remainder_o=16.
- 0/5 → quotient_o=0x000, remainder_o=0.
- 7/0 → valid_o on the next cycle; quotient_o=0xFFF, remainder_o=7, div_by_zero_o=1.
- Backpressure: run 200/3 and hold yumi_i=0 for 5 cycles → valid_o stays 1, quotient_o=0x42A and remainder_o=2 stable, ready_o=0 throughout, and valid_i pulses are ignored.
- Assert reset_i at cycle 6 of a BUSY operation → immediate IDLE, valid_o never rises; a following 100/7 returns 0x0E4 rem 4.
- Sweep the 20-value set {0,1,2,3,4,5,7,15,31,63,127,255, …} pairwise:
  - Against a reference model; values are truncated to width_p.
  - Every nonzero divisor must satisfy quotient*divisor + remainder == dividend<<frac_p.
